// File: rtl/lcd_timer_pkg.sv
// Shared types and LCD delay constants for the LCD delay timer.
// Tick constants assume the default 1 us tick (PRESCALE_1US clocks at 50 MHz).
package lcd_timer_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } timer_state_t;

   localparam int PRESCALE_1US = 50;

   localparam int DLY_CMD_40US   = 40;
   localparam int DLY_100US      = 100;
   localparam int DLY_CLR_1640US = 1640;
   localparam int DLY_PWRON_15MS = 15000;

endpackage

// File: rtl/lcd_tick_prescaler.sv
// Free-running 0..PRESCALE-1 counter producing a one-cycle tick on its last count.
// Tick is combinational from the count register; clear beats enable and holds the count at 0.
module lcd_tick_prescaler #(
   parameter int PRESCALE = 50
) (
   input  logic clock,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] cnt;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         if (cnt == LAST) cnt <= '0;
         else             cnt <= cnt + PS_W'(1);
      end
   end

   assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/lcd_delay_timer.sv
// Retriggerable one-shot/periodic delay timer: start -> done after delay_ticks*PRESCALE clocks.
// All outputs registered; cancel has top priority. LCD_TIMER_RETRIGGER_EN lets start restart a running delay.
module lcd_delay_timer
   import lcd_timer_pkg::*;
#(
   parameter int PRESCALE = PRESCALE_1US,
   parameter int CNT_W    = 16
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] delay_ticks,
   input  logic             periodic,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining
);

   localparam logic [0:0] IDLE = ST_IDLE;
   localparam logic [0:0] RUN  = ST_RUN;

   logic [0:0]       state;
   logic [CNT_W-1:0] reload;
   logic             periodic_q;
   logic             tick;
   logic             ps_clear;
   logic             zero_delay;

   assign zero_delay = (delay_ticks == '0);

`ifdef LCD_TIMER_RETRIGGER_EN
   assign ps_clear = cancel || (state == IDLE) || start;
`else
   assign ps_clear = cancel || (state == IDLE);
`endif

   lcd_tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clock  (clock),
      .rst    (rst),
      .clear  (ps_clear),
      .enable (state == RUN),
      .tick   (tick)
   );

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         remaining  <= '0;
         reload     <= '0;
         periodic_q <= 1'b0;
      end else begin
         done <= 1'b0;
         if (cancel) begin
            state     <= IDLE;
            busy      <= 1'b0;
            remaining <= '0;
         end else if (state == IDLE) begin
            if (start) begin
               if (zero_delay) begin
                  done <= 1'b1;
               end else begin
                  state      <= RUN;
                  busy       <= 1'b1;
                  reload     <= delay_ticks;
                  remaining  <= delay_ticks;
                  periodic_q <= periodic;
               end
            end
         end else begin
`ifdef LCD_TIMER_RETRIGGER_EN
            // Restart wins over a coinciding tick, so the aborted period never reports done.
            if (start) begin
               reload     <= delay_ticks;
               remaining  <= delay_ticks;
               periodic_q <= periodic;
               if (zero_delay) begin
                  done  <= 1'b1;
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end else
`endif
            if (tick) begin
               if (remaining == CNT_W'(1)) begin
                  done <= 1'b1;
                  if (periodic_q) begin
                     remaining <= reload;
                  end else begin
                     remaining <= '0;
                     state     <= IDLE;
                     busy      <= 1'b0;
                  end
               end else begin
                  remaining <= remaining - CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lcd_delay_timer.sv
// Directed bench for lcd_delay_timer with PRESCALE=4; expectations follow the retrigger macro if defined.
module tb_lcd_delay_timer;

   localparam int PS = 4;
   localparam int W  = 16;

   logic         clock;
   logic         rst;
   logic         start;
   logic [W-1:0] delay_ticks;
   logic         periodic;
   logic         cancel;
   logic         busy;
   logic         done;
   logic [W-1:0] remaining;

   int checks = 0;
   int errors = 0;

   lcd_delay_timer #(
      .PRESCALE (PS),
      .CNT_W    (W)
   ) dut (
      .clock       (clock),
      .rst         (rst),
      .start       (start),
      .delay_ticks (delay_ticks),
      .periodic    (periodic),
      .cancel      (cancel),
      .busy        (busy),
      .done        (done),
      .remaining   (remaining)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input int k, input int eb, input int ed, input int er);
      chk($sformatf("%s.busy@%0d", tag, k), {31'd0, busy}, eb);
      chk($sformatf("%s.done@%0d", tag, k), {31'd0, done}, ed);
      chk($sformatf("%s.rem@%0d", tag, k), {16'd0, remaining}, er);
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   initial begin
      int er;
      rst         = 1'b1;
      start       = 1'b0;
      delay_ticks = '0;
      periodic    = 1'b0;
      cancel      = 1'b0;
      #1;
      chk3("reset", 0, 0, 0, 0);
      tick;
      tick;
      rst = 1'b0;
      tick;
      chk3("idle", 0, 0, 0, 0);

      // One-shot, 3 ticks: done 12 cycles after the start edge.
      start = 1'b1; delay_ticks = 3; periodic = 1'b0;
      tick;
      start = 1'b0;
      chk3("oneshot", 0, 1, 0, 3);
      for (int k = 1; k <= 14; k++) begin
         tick;
         chk3("oneshot", k, (k < 12) ? 1 : 0, (k == 12) ? 1 : 0, (k < 12) ? 3 - k / 4 : 0);
      end

      // Periodic, 2 ticks: done at +8, +16; cancel sampled at +20.
      start = 1'b1; delay_ticks = 2; periodic = 1'b1;
      tick;
      start = 1'b0; periodic = 1'b0;
      chk3("periodic", 0, 1, 0, 2);
      for (int k = 1; k <= 19; k++) begin
         tick;
         chk3("periodic", k, 1, (k % 8 == 0) ? 1 : 0, ((k % 8) < 4) ? 2 : 1);
      end
      cancel = 1'b1;
      tick;
      cancel = 1'b0;
      chk3("per_cancel", 20, 0, 0, 0);
      for (int k = 21; k <= 27; k++) begin
         tick;
         chk3("per_after", k, 0, 0, 0);
      end

      // Cancel on the same edge as the final tick of a 1-tick delay.
      start = 1'b1; delay_ticks = 1;
      tick;
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick;
         chk3("cfinal", k, 1, 0, 1);
      end
      cancel = 1'b1;
      tick;
      cancel = 1'b0;
      chk3("cfinal", 4, 0, 0, 0);
      tick;
      chk3("cfinal", 5, 0, 0, 0);

      // Simultaneous cancel and start: start is dropped.
      start = 1'b1; cancel = 1'b1; delay_ticks = 5;
      tick;
      start = 1'b0; cancel = 1'b0;
      chk3("cstart", 0, 0, 0, 0);
      tick;
      chk3("cstart", 1, 0, 0, 0);

      // Zero delay: done next cycle, busy never rises.
      start = 1'b1; delay_ticks = 0; periodic = 1'b1;
      tick;
      start = 1'b0; periodic = 1'b0;
      chk3("zero", 0, 0, 1, 0);
      tick;
      chk3("zero", 1, 0, 0, 0);
      tick;
      chk3("zero", 2, 0, 0, 0);

      // Mid-delay start of 5 ticks sampled at edge +5 of a 3-tick delay.
      start = 1'b1; delay_ticks = 3;
      tick;
      start = 1'b0;
      for (int k = 1; k <= 27; k++) begin
         if (k == 5) begin
            start = 1'b1; delay_ticks = 5;
         end
         tick;
         start = 1'b0;
`ifdef LCD_TIMER_RETRIGGER_EN
         if (k < 5)       er = 3 - k / 4;
         else if (k < 25) er = 5 - (k - 5) / 4;
         else             er = 0;
         chk3("retrig", k, (k < 25) ? 1 : 0, (k == 25) ? 1 : 0, er);
`else
         er = (k < 12) ? 3 - k / 4 : 0;
         chk3("retrig", k, (k < 12) ? 1 : 0, (k == 12) ? 1 : 0, er);
`endif
      end

      // Asynchronous reset pulsed between clock edges mid-RUN.
      start = 1'b1; delay_ticks = 4;
      tick;
      start = 1'b0;
      for (int k = 1; k <= 6; k++) tick;
      chk3("prerst", 6, 1, 0, 3);
      #2;
      rst = 1'b1;
      #1;
      chk3("async_rst", 0, 0, 0, 0);
      #1;
      rst = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick;
         chk3("post_rst", k, 0, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
